// File: rtl/vector_mem_unit_if.sv
// Request/response and byte-memory bus bundle for vector_mem_unit.
// The stride signal exists only when VMU_STRIDE_EN is defined.
interface vector_mem_unit_if #(
  parameter int A     = 32,
  parameter int L     = 8,
  parameter int LANES = 8
);
  logic                 start;
  logic                 op_store;
  logic [A-1:0]         base_addr;
`ifdef VMU_STRIDE_EN
  logic [A-1:0]         stride;
`endif
  logic [LANES*L-1:0]   vec_wdata;
  logic [LANES*L-1:0]   vec_rdata;
  logic                 busy;
  logic                 done;
  logic                 rom_write_err;
  logic [A-1:0]         mem_address;
  logic [L-1:0]         mem_write_data;
  logic                 mem_write_enable;
  logic [L-1:0]         mem_read_data;

`ifdef VMU_STRIDE_EN
  modport slave (
    input  start, op_store, base_addr, stride, vec_wdata, mem_read_data,
    output vec_rdata, busy, done, rom_write_err,
    output mem_address, mem_write_data, mem_write_enable
  );
  modport master (
    output start, op_store, base_addr, stride, vec_wdata, mem_read_data,
    input  vec_rdata, busy, done, rom_write_err,
    input  mem_address, mem_write_data, mem_write_enable
  );
`else
  modport slave (
    input  start, op_store, base_addr, vec_wdata, mem_read_data,
    output vec_rdata, busy, done, rom_write_err,
    output mem_address, mem_write_data, mem_write_enable
  );
  modport master (
    output start, op_store, base_addr, vec_wdata, mem_read_data,
    input  vec_rdata, busy, done, rom_write_err,
    input  mem_address, mem_write_data, mem_write_enable
  );
`endif
endinterface

// File: rtl/vector_mem_unit.sv
// Vector load/store unit: turns one vector request into LANES byte accesses
// on a byte-wide ROM/RAM memory. Optional feature macro: VMU_STRIDE_EN.
module vector_mem_unit #(
  parameter int A     = 32,
  parameter int L     = 8,
  parameter int LANES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  vector_mem_unit_if.slave  vif
);

  localparam int           LW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [A-1:0] RAM_BASE = A'(32'h0000_FFFF);
  localparam logic [LW-1:0] LAST    = LW'(LANES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ADDR,
    S_LD_CAP,
    S_ST_WR,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [A-1:0]         addr_q, addr_d;
  logic [LANES*L-1:0]   wdata_q, wdata_d;
  logic [LANES*L-1:0]   rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [A-1:0]         incr;
  logic                 in_ram;
  logic                 busy, done, mem_we;

  function automatic logic [L-1:0] lane_of(input logic [LANES*L-1:0] v,
                                           input logic [LW-1:0]      i);
    return v[i*L +: L];
  endfunction

  function automatic logic is_ram(input logic [A-1:0] a);
    return (a >= RAM_BASE);
  endfunction

`ifdef VMU_STRIDE_EN
  logic [A-1:0] stride_q, stride_d;
  assign incr = stride_q;
`else
  assign incr = A'(1);
`endif

  assign in_ram = is_ram(addr_q);

  // Next-state and outputs; the lane address lives in addr_q and is
  // advanced only when leaving a lane so it stays valid through capture.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef VMU_STRIDE_EN
    stride_d = stride_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vif.start) begin
          addr_d   = vif.base_addr;
          wdata_d  = vif.vec_wdata;
          lane_d   = '0;
          err_d    = 1'b0;
`ifdef VMU_STRIDE_EN
          stride_d = vif.stride;
`endif
          state_d  = vif.op_store ? S_ST_WR : S_LD_ADDR;
        end
      end

      S_LD_ADDR: begin
        busy    = 1'b1;
        state_d = S_LD_CAP;
      end

      S_LD_CAP: begin
        busy = 1'b1;
        rdata_d[lane_q*L +: L] = vif.mem_read_data;
        if (lane_q == LAST) begin
          state_d = S_DONE;
        end else begin
          lane_d  = lane_q + LW'(1);
          addr_d  = addr_q + incr;
          state_d = S_LD_ADDR;
        end
      end

      S_ST_WR: begin
        busy   = 1'b1;
        mem_we = in_ram;
        // ROM-targeted lanes are consumed without a write but flagged
        if (!in_ram) err_d = 1'b1;
        if (lane_q == LAST) begin
          state_d = S_DONE;
        end else begin
          lane_d = lane_q + LW'(1);
          addr_d = addr_q + incr;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef VMU_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef VMU_STRIDE_EN
      stride_q <= stride_d;
`endif
    end
  end

  assign vif.mem_address      = addr_q;
  assign vif.mem_write_data   = lane_of(wdata_q, lane_q);
  assign vif.mem_write_enable = mem_we;
  assign vif.vec_rdata        = rdata_q;
  assign vif.busy             = busy;
  assign vif.done             = done;
  assign vif.rom_write_err    = err_q;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Scoreboard bench for vector_mem_unit with a byte ROM/RAM memory model.
module tb_vector_mem_unit;
  localparam int          A        = 32;
  localparam int          L        = 8;
  localparam int          LANES    = 8;
  localparam logic [31:0] RAM_BASE = 32'h0000_FFFF;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct packed {
    logic [63:0] vec;
    logic        err;
    logic [31:0] busy;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_mem_unit_if #(.A(A), .L(L), .LANES(LANES)) vif ();

  vector_mem_unit #(.A(A), .L(L), .LANES(LANES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  // Memory model: ROM byte at address a is a[7:0]; RAM is a small hashed array.
  logic [7:0] ram [0:1023];
  logic [7:0] rom_rd, ram_rd;

  function automatic logic [9:0] ram_idx(input logic [31:0] a);
    return {a[17:16], a[7:0]};
  endfunction

  initial for (int i = 0; i < 1024; i++) ram[i] = 8'h00;

  always @(posedge clk) begin
    rom_rd <= vif.mem_address[7:0];
    ram_rd <= ram[ram_idx(vif.mem_address)];
    if (vif.mem_write_enable) ram[ram_idx(vif.mem_address)] <= vif.mem_write_data;
  end

  assign vif.mem_read_data = (vif.mem_address < RAM_BASE) ? rom_rd : ram_rd;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Reference contents and scoreboard queues
  logic [7:0]  ref_ram [logic [31:0]];
  logic [63:0] last_vec = '0;
  wr_t         exp_wr [$];
  res_t        exp_res [$];
  int          busy_cnt = 0;

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (a < RAM_BASE) return a[7:0];
    if (ref_ram.exists(a)) return ref_ram[a];
    return 8'h00;
  endfunction

  always @(negedge clk) begin : monitor
    wr_t  w;
    res_t r;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (vif.busy) busy_cnt++;
      if (vif.mem_write_enable) begin
        if (exp_wr.size() == 0) begin
          chk("wr_unexpected", 64'(vif.mem_address), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 64'(vif.mem_address), 64'(w.a));
          chk("wr_data", 64'(vif.mem_write_data), 64'(w.d));
        end
      end
      if (vif.done) begin
        if (exp_res.size() == 0) begin
          chk("done_unexpected", 64'(vif.done), 64'd0);
        end else begin
          r = exp_res.pop_front();
          chk("vec_rdata", vif.vec_rdata, r.vec);
          chk("rom_write_err", 64'(vif.rom_write_err), 64'(r.err));
          chk("busy_cycles", 64'(busy_cnt), 64'(r.busy));
          chk("writes_left", 64'(exp_wr.size()), 64'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input bit st, input logic [31:0] base, input logic [31:0] strd,
                       input logic [63:0] wd, input int keep_lanes, input bit want_done);
    res_t        r;
    wr_t         w;
    logic [31:0] a;
    @(negedge clk);
    a     = base;
    r.vec = last_vec;
    r.err = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (st) begin
        if (a >= RAM_BASE) begin
          if (k < keep_lanes) begin
            w.a = a;
            w.d = wd[k*8 +: 8];
            exp_wr.push_back(w);
            ref_ram[a] = wd[k*8 +: 8];
          end
        end else begin
          r.err = 1'b1;
        end
      end else begin
        r.vec[k*8 +: 8] = ref_rd(a);
      end
      a = a + strd;
    end
    r.busy = st ? 32'(LANES) : 32'(2 * LANES);
    if (want_done) begin
      exp_res.push_back(r);
      last_vec = r.vec;
    end
    vif.start     = 1'b1;
    vif.op_store  = st;
    vif.base_addr = base;
    vif.vec_wdata = wd;
`ifdef VMU_STRIDE_EN
    vif.stride    = strd;
`endif
    @(negedge clk);
    vif.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (vif.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic run_op(input bit st, input logic [31:0] base, input logic [31:0] strd,
                        input logic [63:0] wd);
    issue(st, base, strd, wd, LANES, 1'b1);
    wait_done(100);
    @(negedge clk);
    chk("done_one_cycle", 64'(vif.done), 64'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    vif.start     = 1'b0;
    vif.op_store  = 1'b0;
    vif.base_addr = '0;
    vif.vec_wdata = '0;
`ifdef VMU_STRIDE_EN
    vif.stride    = 32'd1;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(vif.busy), 64'd0);
    chk("rst_done", 64'(vif.done), 64'd0);
    chk("rst_we", 64'(vif.mem_write_enable), 64'd0);
    chk("rst_err", 64'(vif.rom_write_err), 64'd0);
    chk("rst_vec", vif.vec_rdata, 64'd0);
    chk("rst_addr", 64'(vif.mem_address), 64'd0);
    chk("rst_wdata", 64'(vif.mem_write_data), 64'd0);
    rst_n = 1'b1;

    // Unit-stride ROM load
    run_op(1'b0, 32'h0000_0010, 32'd1, 64'd0);
    chk("rom_load_vec", vif.vec_rdata, 64'h1716_1514_1312_1110);

    // RAM store then load back
    run_op(1'b1, 32'h0001_0000, 32'd1, 64'h8877_6655_4433_2211);
    run_op(1'b0, 32'h0001_0000, 32'd1, 64'd0);
    chk("ram_loadback", vif.vec_rdata, 64'h8877_6655_4433_2211);

    // Store/load straddling the ROM/RAM boundary
    run_op(1'b1, 32'h0000_FFFC, 32'd1, 64'hA7A6_A5A4_A3A2_A1A0);
    run_op(1'b0, 32'h0000_FFFC, 32'd1, 64'd0);
    chk("boundary_vec", vif.vec_rdata, 64'hA7A6_A5A4_A3FE_FDFC);

    // start during busy and during DONE is ignored; next IDLE start accepted
    issue(1'b0, 32'h0000_0018, 32'd1, 64'd0, LANES, 1'b1);
    repeat (2) @(negedge clk);
    vif.start     = 1'b1;
    vif.op_store  = 1'b1;
    vif.base_addr = 32'h0004_0000;
    vif.vec_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    vif.start = 1'b0;
    wait_done(100);
    vif.start     = 1'b1;
    vif.op_store  = 1'b1;
    vif.base_addr = 32'h0005_0000;
    vif.vec_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    issue(1'b1, 32'h0003_0000, 32'd1, 64'h3736_3534_3332_3130, LANES, 1'b1);
    chk("idle_start_busy", 64'(vif.busy), 64'd1);
    wait_done(100);
    @(negedge clk);

    // Reset while lane 4 of a store is on the bus
    issue(1'b1, 32'h0002_0000, 32'd1, 64'h0807_0605_0403_0201, 4, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    chk("abort_lane4_addr", 64'(vif.mem_address), 64'h2_0004);
    chk("abort_lane4_we", 64'(vif.mem_write_enable), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_async", 64'(vif.mem_write_enable), 64'd0);
    chk("abort_busy", 64'(vif.busy), 64'd0);
    chk("abort_addr", 64'(vif.mem_address), 64'd0);
    chk("abort_vec", vif.vec_rdata, 64'd0);
    last_vec = '0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_writes_left", 64'(exp_wr.size()), 64'd0);
    rst_n = 1'b1;
    run_op(1'b0, 32'h0002_0000, 32'd1, 64'd0);
    chk("abort_ram_contents", vif.vec_rdata, 64'h0000_0000_0403_0201);

    // Address wrap past the top of the address space
    run_op(1'b1, 32'hFFFF_FFFC, 32'd1, 64'h1F1E_1D1C_1B1A_1918);
    run_op(1'b0, 32'hFFFF_FFFC, 32'd1, 64'd0);
    chk("wrap_vec", vif.vec_rdata, 64'h0302_0100_1B1A_1918);

`ifdef VMU_STRIDE_EN
    run_op(1'b0, 32'hFFFF_FFFC, 32'd2, 64'd0);
    chk("stride2_vec", vif.vec_rdata, 64'h0A08_0604_0200_1A18);
    run_op(1'b0, 32'h0001_0003, 32'd0, 64'd0);
    chk("stride0_vec", vif.vec_rdata, 64'hA7A7_A7A7_A7A7_A7A7);
`endif

    repeat (2) @(negedge clk);
    chk("results_left", 64'(exp_res.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
